sata_scrambler_ctrl: RTL
========================

// Module: sata_scrambler_ctrl
// PURPOSE
//  Sequences an external LFSR generator (32-bit step per clock) to scramble a SATA link-layer dword stream.
//  Reinitialises the LFSR at frame boundaries and advances it only on scrambled data dwords.
//  XORs the LFSR mask onto the frame contents; primitives pass through unscrambled.
//  Sits between the link-layer framer and the 8b/10b/PHY transmit path; one output register stage.
// PARAMETERS
//  FRAMEMAX   2048  max data dwords per frame (SOP..EOP inclusive, primitives excluded); >=2
// PORTS
//  clk         in   1   clock
//  reset_n     in   1   asynchronous reset, active low
//  enable      in   1   scrambling enable; sampled on SOP acceptance, held for the frame
//  i_dat       in   32  input dword
//  i_val       in   1   input valid
//  i_sop       in   1   first data dword of frame
//  i_eop       in   1   last data dword of frame
//  i_prim      in   1   dword is a primitive (overrides i_sop/i_eop)
//  i_rdy       out  1   input ready
//  o_dat       out  32  output dword
//  o_val       out  1   output valid
//  o_sop       out  1   registered copy of i_sop
//  o_eop       out  1   registered copy of i_eop
//  o_prim      out  1   registered copy of i_prim
//  o_rdy       in   1   downstream ready
//  lfsr_ena    out  1   to LFSR clkena; advance (or init when lfsr_init=1)
//  lfsr_init   out  1   to LFSR init; always qualified by lfsr_ena
//  lfsr_data   in   32  current LFSR mask (LFSR register bits [31:0])
//  frame_err   out  1   one-cycle pulse on protocol/length error
// BEHAVIOUR
//  Reset: o_val=0, o_dat=0, o_sop/o_eop/o_prim=0, frame_err=0, state=IDLE, count=0, scr_en=0.
//  The LFSR must also reset to its seed value.
//  Transfer rules:
//   - xfer_in = i_val & i_rdy; xfer_out = o_val & o_rdy.
//   - i_rdy = (state!=REINIT) & (~o_val | o_rdy).
//   - o_* are held stable while o_val & ~o_rdy.
//  Latency: exactly 1 clk from xfer_in to o_val. o_val drops after xfer_out if there is no new xfer_in.
//  Dword classes on xfer_in:
//   - Primitive (i_prim=1): o_dat=i_dat; no lfsr_ena; count unchanged; legal in any state.
//   - Frame data (SOP in IDLE, or any non-prim in DATA): o_dat = scr_en ? i_dat^lfsr_data : i_dat.
//     lfsr_ena=1 in the same cycle iff scr_en (effective value, including the SOP cycle).
//   - Non-prim, non-SOP dword in IDLE: passed unscrambled; no LFSR action; no error.
//  FSM:
//   - IDLE -> DATA: on SOP xfer_in; count<=1; scr_en<=enable.
//     SOP together with EOP: single-dword frame; stays IDLE and performs the EOP actions.
//   - DATA -> IDLE: on EOP xfer_in. lfsr_ena=1 and lfsr_init=1 in that cycle, so the next SOP sees the seed.
//     Init is issued even if scr_en=0.
//   - DATA -> REINIT: on i_sop & i_val & ~i_prim (missing EOP).
//     The dword is NOT accepted (i_rdy is forced 0 that cycle). frame_err=1.
//   - REINIT -> IDLE: after 1 clk with lfsr_ena=1, lfsr_init=1, i_rdy=0. The pending SOP is then accepted from IDLE.
//  Length check: count increments on each frame-data xfer_in and saturates at FRAMEMAX+1.
//   - frame_err pulses once, on the xfer_in that takes count from FRAMEMAX to FRAMEMAX+1.
//   - Data keeps flowing scrambled; no other effect.
//  Simultaneous events:
//   - lfsr_init is never asserted without lfsr_ena.
//   - A stall (o_val & ~o_rdy) suppresses all LFSR action.
//  Async reset mid-frame: returns to IDLE and discards the output register; LFSR reset is external.
// TESTING
//  T1 reset: hold reset_n=0 -> o_val=0, lfsr_ena=0, lfsr_init=0, frame_err=0, i_rdy=1 after release.
//  T2 frame: enable=1, SOP+D1+D2+EOP, o_rdy=1, LFSR model seeded 0xC2D2768D
//     -> o_dat = i_dat^mask per dword, 1 clk later; 4 lfsr_ena pulses; lfsr_init on the EOP cycle.
//  T3 primitive mid-frame: insert HOLD 0x7CAA... between D1 and D2 -> output unchanged, no lfsr_ena.
//     D2 still gets the 3rd mask.
//  T4 backpressure: o_rdy=0 for 3 clk mid-frame -> i_rdy=0, o_* stable, no lfsr_ena.
//     Stream resumes with no mask skipped.
//  T5 missing EOP: SOP,D1,SOP -> frame_err=1 for 1 clk; i_rdy=0 for 1 clk with lfsr_ena&lfsr_init=1.
//     The second SOP is scrambled with the seed mask.
//  T6 overlength: FRAMEMAX=4, frame of 6 data dwords -> frame_err pulses on the 5th dword only.
//     All 6 are scrambled; enable=0 frame -> o_dat=i_dat, lfsr_ena only at EOP (with init).

Source files
------------

// File: rtl/sata_scrambler_ctrl.sv
// rtl/sata_scrambler_ctrl.sv - SATA link-layer scrambler sequencer driving an external 32-bit LFSR
module sata_scrambler_ctrl #(
  parameter int FRAMEMAX = 2048
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] i_dat,
  input  logic        i_val,
  input  logic        i_sop,
  input  logic        i_eop,
  input  logic        i_prim,
  output logic        i_rdy,
  output logic [31:0] o_dat,
  output logic        o_val,
  output logic        o_sop,
  output logic        o_eop,
  output logic        o_prim,
  input  logic        o_rdy,
  output logic        lfsr_ena,
  output logic        lfsr_init,
  input  logic [31:0] lfsr_data,
  output logic        frame_err
);

  localparam int CW = $clog2(FRAMEMAX + 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(FRAMEMAX);
  localparam logic [CW-1:0] CNT_SAT = CW'(FRAMEMAX + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    REINIT = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          scr_en;

  logic stall;
  logic early_sop;
  logic xfer_in;
  logic is_sop;
  logic frame_dat;
  logic eff_scr;
  logic reinit_go;
  logic len_err;

  // Handshake and dword classification for the current cycle
  always_comb begin
    stall     = o_val & ~o_rdy;
    // A new SOP arriving inside a frame means the EOP was lost; it is held off until reinit
    early_sop = (state == DATA) & i_val & i_sop & ~i_prim;
    i_rdy     = (state != REINIT) & ~stall & ~early_sop;
    xfer_in   = i_val & i_rdy;
    is_sop    = ~i_prim & i_sop & (state == IDLE);
    frame_dat = ~i_prim & (is_sop | (state == DATA));
    // The SOP dword itself already uses the freshly sampled enable
    eff_scr   = is_sop ? enable : scr_en;
    reinit_go = (state == REINIT) & ~stall;
    len_err   = xfer_in & frame_dat & ~is_sop & (count == CNT_MAX);
  end

  // LFSR sequencing: advance on scrambled frame data, reseed at frame end or after a lost EOP
  always_comb begin
    lfsr_ena  = reinit_go | (xfer_in & frame_dat & (eff_scr | i_eop));
    lfsr_init = reinit_go | (xfer_in & frame_dat & i_eop);
  end

  // Frame FSM with dword counter, sampled scramble enable and registered error pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      count     <= '0;
      scr_en    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= early_sop | len_err;
      if (xfer_in && frame_dat) begin
        if (is_sop) begin
          count  <= CNT_ONE;
          scr_en <= enable;
        end else if (count != CNT_SAT) begin
          count <= count + CNT_ONE;
        end
      end
      case (state)
        IDLE: begin
          if (xfer_in && is_sop && !i_eop) state <= DATA;
        end
        DATA: begin
          if (early_sop)                           state <= REINIT;
          else if (xfer_in && frame_dat && i_eop)  state <= IDLE;
        end
        REINIT: begin
          if (!stall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Single output register stage; held while downstream stalls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_dat  <= '0;
      o_val  <= 1'b0;
      o_sop  <= 1'b0;
      o_eop  <= 1'b0;
      o_prim <= 1'b0;
    end else if (xfer_in) begin
      o_dat  <= (frame_dat && eff_scr) ? (i_dat ^ lfsr_data) : i_dat;
      o_val  <= 1'b1;
      o_sop  <= i_sop;
      o_eop  <= i_eop;
      o_prim <= i_prim;
    end else if (o_rdy) begin
      o_val <= 1'b0;
    end
  end

endmodule
